// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron pipeline (LIF neuron and STDP stage).
package snn_pkg;

    localparam int unsigned NUM_PRE_DEFAULT = 4;
    localparam int unsigned W_WIDTH_DEFAULT = 4;
    localparam int unsigned V_WIDTH_DEFAULT = 8;
    localparam int unsigned SUM_WIDTH       = 6;

    typedef enum logic [0:0] {
        INTEGRATE  = 1'b0,
        REFRACTORY = 1'b1
    } lif_state_e;

    // Neuron 0 occupies the most significant weight nibble, neuron NUM_PRE-1 the least.
    function automatic logic [W_WIDTH_DEFAULT-1:0] weight_slice(
        input logic [NUM_PRE_DEFAULT*W_WIDTH_DEFAULT-1:0] w,
        input int unsigned                                idx
    );
        return w[(NUM_PRE_DEFAULT-1-idx)*W_WIDTH_DEFAULT +: W_WIDTH_DEFAULT];
    endfunction

endpackage

// File: rtl/spike_weight_sum.sv
// Combinational masked adder: sums the weights of presynaptic inputs that spiked.
module spike_weight_sum
    import snn_pkg::*;
(
    input  logic [NUM_PRE_DEFAULT-1:0]                 pre_spike,
    input  logic [NUM_PRE_DEFAULT*W_WIDTH_DEFAULT-1:0] weight,
    output logic [SUM_WIDTH-1:0]                       sum
);

    // Accumulate the weight of every spiking input; no arbitration between inputs.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NUM_PRE_DEFAULT; i++) begin
            if (pre_spike[i]) begin
                sum = sum + SUM_WIDTH'(weight_slice(weight, i));
            end
        end
    end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: leaky membrane, threshold fire, refractory hold.
module lif_neuron #(
    parameter int unsigned NUM_PRE        = snn_pkg::NUM_PRE_DEFAULT,
    parameter int unsigned W_WIDTH        = snn_pkg::W_WIDTH_DEFAULT,
    parameter int unsigned V_WIDTH        = snn_pkg::V_WIDTH_DEFAULT,
    parameter int unsigned THRESHOLD      = 40,
    parameter int unsigned LEAK_SHIFT     = 3,
    parameter int unsigned REFRACT_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_PRE-1:0]         pre_spike,
    input  logic [NUM_PRE*W_WIDTH-1:0] weight,
    output logic                       post_spike,
    output logic [V_WIDTH-1:0]         membrane,
    output logic                       refractory,
    output logic [7:0]                 spike_count
);
    import snn_pkg::*;

    lif_state_e           state_q;
    logic [V_WIDTH-1:0]   membrane_q;
    logic                 post_spike_q;
    logic [3:0]           refr_cnt_q;
    logic [7:0]           spike_count_q;

    logic [SUM_WIDTH-1:0] sum;
    logic [V_WIDTH-1:0]   leak;
    logic [V_WIDTH:0]     v_wide;
    logic [V_WIDTH-1:0]   v_next_d;
    logic                 fire;

    spike_weight_sum u_sum (
        .pre_spike (pre_spike),
        .weight    (weight),
        .sum       (sum)
    );

    // Leak first, then add input; one spare bit catches overflow for saturation.
    always_comb begin
        leak     = membrane_q >> LEAK_SHIFT;
        v_wide   = {1'b0, membrane_q - leak} + (V_WIDTH+1)'(sum);
        v_next_d = v_wide[V_WIDTH] ? '1 : v_wide[V_WIDTH-1:0];
        fire     = (v_next_d >= V_WIDTH'(THRESHOLD));
    end

    // FSM with membrane, refractory counter and spike counter; post_spike self-clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= INTEGRATE;
            membrane_q    <= '0;
            post_spike_q  <= 1'b0;
            refr_cnt_q    <= '0;
            spike_count_q <= '0;
        end else begin
            post_spike_q <= 1'b0;
            if (en) begin
                case (state_q)
                    INTEGRATE: begin
                        if (fire) begin
                            post_spike_q  <= 1'b1;
                            membrane_q    <= '0;
                            spike_count_q <= spike_count_q + 8'd1;
                            refr_cnt_q    <= 4'(REFRACT_CYCLES);
                            state_q       <= REFRACTORY;
                        end else begin
                            membrane_q <= v_next_d;
                        end
                    end
                    REFRACTORY: begin
                        membrane_q <= '0;
                        if (refr_cnt_q == 4'd1) begin
                            refr_cnt_q <= '0;
                            state_q    <= INTEGRATE;
                        end else begin
                            refr_cnt_q <= refr_cnt_q - 4'd1;
                        end
                    end
                    default: state_q <= INTEGRATE;
                endcase
            end
        end
    end

    assign post_spike  = post_spike_q;
    assign membrane    = membrane_q;
    assign refractory  = (state_q == REFRACTORY);
    assign spike_count = spike_count_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: scoreboard of expected outputs per clock edge.
module tb_lif_neuron;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  pre_spike;
    logic [15:0] weight;

    logic        post_a, refr_a;
    logic [7:0]  mem_a, cnt_a;
    logic        post_b, refr_b;
    logic [7:0]  mem_b, cnt_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          use_sat  = 1'b0;

    typedef struct {
        string      tag;
        logic [7:0] mem;
        logic       post;
        logic       refr;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    lif_neuron dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pre_spike   (pre_spike),
        .weight      (weight),
        .post_spike  (post_a),
        .membrane    (mem_a),
        .refractory  (refr_a),
        .spike_count (cnt_a)
    );

    lif_neuron #(.THRESHOLD(255)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pre_spike   (pre_spike),
        .weight      (weight),
        .post_spike  (post_b),
        .membrane    (mem_b),
        .refractory  (refr_b),
        .spike_count (cnt_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Push the expectation for the coming edge, advance, then pop and compare.
    task automatic cyc(input string tag, input int mem, input bit post, input bit refr, input int cnt);
        exp_t e;
        exp_t got;
        e.tag  = tag;
        e.mem  = 8'(mem);
        e.post = post;
        e.refr = refr;
        e.cnt  = 8'(cnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        if (use_sat) begin
            check({got.tag, ".membrane"},    mem_b,        got.mem);
            check({got.tag, ".post_spike"},  {7'd0, post_b}, {7'd0, got.post});
            check({got.tag, ".refractory"},  {7'd0, refr_b}, {7'd0, got.refr});
            check({got.tag, ".spike_count"}, cnt_b,        got.cnt);
        end else begin
            check({got.tag, ".membrane"},    mem_a,        got.mem);
            check({got.tag, ".post_spike"},  {7'd0, post_a}, {7'd0, got.post});
            check({got.tag, ".refractory"},  {7'd0, refr_a}, {7'd0, got.refr});
            check({got.tag, ".spike_count"}, cnt_a,        got.cnt);
        end
    endtask

    initial begin
        int leak_seq[15];
        leak_seq = '{26, 23, 21, 19, 17, 15, 14, 13, 12, 11, 10, 9, 8, 7, 7};

        // Reset with random inputs
        rst       = 1'b1;
        en        = 1'b1;
        pre_spike = 4'($urandom);
        weight    = 16'($urandom);
        cyc("reset0", 0, 0, 0, 0);
        pre_spike = 4'($urandom);
        weight    = 16'($urandom);
        cyc("reset1", 0, 0, 0, 0);

        // Single-input integrate and fire
        rst       = 1'b0;
        weight    = 16'hF000;
        pre_spike = 4'b0001;
        cyc("int1", 15, 0, 0, 0);
        cyc("int2", 29, 0, 0, 0);
        cyc("fire1", 0, 1, 1, 1);

        // Refractory with inputs still driven
        cyc("refr1", 0, 0, 1, 1);
        cyc("refr2", 0, 0, 1, 1);
        cyc("refr3", 0, 0, 1, 1);
        cyc("refr_end", 0, 0, 0, 1);
        cyc("restart1", 15, 0, 0, 1);
        cyc("restart2", 29, 0, 0, 1);

        // Leak decay down to the hold point
        pre_spike = 4'b0000;
        for (int i = 0; i < 15; i++) begin
            cyc($sformatf("leak%0d", i), leak_seq[i], 0, 0, 1);
        end

        // Freeze mid-integration
        pre_spike = 4'b0001;
        en        = 1'b0;
        cyc("freeze_int0", 7, 0, 0, 1);
        cyc("freeze_int1", 7, 0, 0, 1);
        en = 1'b1;
        cyc("resume1", 22, 0, 0, 1);
        cyc("resume2", 35, 0, 0, 1);
        cyc("fire2", 0, 1, 1, 2);

        // Freeze mid-refractory: post_spike still clears
        en = 1'b0;
        cyc("freeze_refr0", 0, 0, 1, 2);
        cyc("freeze_refr1", 0, 0, 1, 2);
        en = 1'b1;
        cyc("refr_after_freeze", 0, 0, 1, 2);

        // Reset during refractory
        rst = 1'b1;
        cyc("reset_refr", 0, 0, 0, 0);
        rst = 1'b0;
        cyc("post_reset_int", 15, 0, 0, 0);

        // Multi-input sums check weight packing: neurons 1,3 then 0,2
        weight    = 16'h1234;
        pre_spike = 4'b1010;
        cyc("multi_13", 20, 0, 0, 0);
        pre_spike = 4'b0101;
        cyc("multi_02", 22, 0, 0, 0);

        // Saturation on the high-threshold instance
        rst = 1'b1;
        cyc("reset_sat_a", 0, 0, 0, 0);
        use_sat = 1'b1;
        cyc("reset_sat_b", 0, 0, 0, 0);
        rst       = 1'b0;
        weight    = 16'hFFFF;
        pre_spike = 4'hF;
        cyc("sat1", 60, 0, 0, 0);
        cyc("sat2", 113, 0, 0, 0);
        cyc("sat3", 159, 0, 0, 0);
        cyc("sat4", 200, 0, 0, 0);
        cyc("sat5", 235, 0, 0, 0);
        cyc("sat_fire", 0, 1, 1, 1);
        cyc("sat_refr", 0, 0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
